// File: rtl/pio_input_irq_if.sv
// rtl/pio_input_irq_if.sv - Avalon-MM slave bus bundle for the input PIO.
interface pio_input_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_input_irq.sv
// rtl/pio_input_irq.sv - input PIO with synchroniser, debounce, edge capture and maskable irq.
module pio_input_irq #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_TYPE        = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pio_input_irq_if.slave       bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);
  localparam int SETTLE = SYNC_STAGES + DEBOUNCE_CYCLES + 2;
  localparam int SW     = $clog2(SETTLE + 1);
  localparam int DC     = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 2;
  localparam int CW     = $clog2(DC);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync, sync_prev_q;
  logic [WIDTH-1:0] filt_q, filt_d, filt_dly_q;
  logic [WIDTH-1:0] mask_q, mask_d, edgecap_q, edgecap_d;
  logic [WIDTH-1:0] rise, fall, edge_hit, clr;
  logic [CW-1:0]    dcnt_q [WIDTH];
  logic [CW-1:0]    dcnt_d [WIDTH];
  logic [SW-1:0]    settle_q, settle_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d, settled, wr;
  logic             unused_wdata;

  assign unused_wdata = ^bus.writedata;
  assign sync     = sync_q[SYNC_STAGES-1];
  assign settled  = (settle_q == SW'(SETTLE));
  assign settle_d = settled ? settle_q : settle_q + SW'(1);
  assign wr       = bus.chipselect & ~bus.write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // A bit's counter only advances while sync is stable and disagrees with filt;
  // during settle the filter is transparent so DATA is valid as soon as capture opens.
  always_comb begin
    filt_d = filt_q;
    dcnt_d = dcnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (DEBOUNCE_CYCLES == 0 || !settled) begin
        filt_d[i] = sync[i];
        dcnt_d[i] = '0;
      end else if (sync[i] == filt_q[i] || sync[i] != sync_prev_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d[i] = sync[i];
        dcnt_d[i] = '0;
      end else begin
        dcnt_d[i] = dcnt_q[i] + CW'(1);
      end
    end
  end

  assign rise     = filt_q & ~filt_dly_q;
  assign fall     = ~filt_q & filt_dly_q;
  assign edge_hit = (EDGE_TYPE == 0) ? rise : (EDGE_TYPE == 1) ? fall : (rise | fall);
  assign clr      = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  // Capture is ORed in after the clear so a same-cycle edge survives the write.
  assign edgecap_d = (edgecap_q & ~clr) | (settled ? edge_hit : '0);
  assign mask_d    = (wr && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : mask_q;
  assign irq_d     = (IRQ_TYPE != 0) ? |(edgecap_q & mask_q) : |(filt_q & mask_q);

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      2'd0:    readdata_d[WIDTH-1:0] = filt_q;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_prev_q <= '0;
      filt_q      <= '0;
      filt_dly_q  <= '0;
      mask_q      <= '0;
      edgecap_q   <= '0;
      irq_q       <= 1'b0;
      readdata_q  <= '0;
      settle_q    <= '0;
      for (int i = 0; i < WIDTH; i++) dcnt_q[i] <= '0;
    end else begin
      sync_prev_q <= sync;
      filt_q      <= filt_d;
      filt_dly_q  <= filt_q;
      mask_q      <= mask_d;
      edgecap_q   <= edgecap_d;
      irq_q       <= irq_d;
      readdata_q  <= readdata_d;
      settle_q    <= settle_d;
      for (int i = 0; i < WIDTH; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;
endmodule

// File: tb/tb_pio_input_irq.sv
// tb/tb_pio_input_irq.sv - self-checking bench: two configurations against a history-based model.
module tb_pio_input_irq;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] addr = 2'd0;
  logic       cs = 1'b0;
  logic       wn = 1'b1;
  logic [31:0] wd = 32'd0;
  logic [7:0] in_port = 8'hFF;
  logic       irq0, irq1;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  pio_input_irq_if bus0 ();
  pio_input_irq_if bus1 ();
  assign bus0.address = addr;  assign bus1.address = addr;
  assign bus0.chipselect = cs; assign bus1.chipselect = cs;
  assign bus0.write_n = wn;    assign bus1.write_n = wn;
  assign bus0.writedata = wd;  assign bus1.writedata = wd;

  pio_input_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_TYPE(0))
    dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq0));
  pio_input_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .IRQ_TYPE(1))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port), .irq(irq1));

  function automatic int dbc(input int i);   return (i == 0) ? 0 : 4; endfunction
  function automatic int etype(input int i); return (i == 0) ? 0 : 2; endfunction
  function automatic int itype(input int i); return (i == 0) ? 0 : 1; endfunction
  function automatic int settle(input int i); return 2 + dbc(i) + 2; endfunction

  // Model: h[k] holds in_port as sampled k+1 edges ago; the synchronised value seen
  // at this edge is h[1], and a bit is accepted once its last D+1 samples agree.
  logic [7:0]  h [16];
  int          ecnt;
  logic [7:0]  m_filt [2];
  logic [7:0]  m_fdly [2];
  logic [7:0]  m_ec   [2];
  logic [7:0]  m_mask [2];
  logic        m_irq  [2];
  logic [31:0] m_rd   [2];

  always @(posedge clk or negedge reset_n) begin : model
    logic [7:0] s, fn, ed, clr;
    bit         same;
    if (!reset_n) begin
      for (int k = 0; k < 16; k++) h[k] <= 8'h00;
      ecnt <= 0;
      for (int i = 0; i < 2; i++) begin
        m_filt[i] <= 8'h00; m_fdly[i] <= 8'h00; m_ec[i] <= 8'h00;
        m_mask[i] <= 8'h00; m_irq[i] <= 1'b0;   m_rd[i] <= 32'd0;
      end
    end else begin
      clr = (cs && !wn && addr == 2'd3) ? wd[7:0] : 8'h00;
      s = h[1];
      for (int i = 0; i < 2; i++) begin
        if (dbc(i) == 0 || ecnt < settle(i)) fn = s;
        else begin
          fn = m_filt[i];
          for (int b = 0; b < 8; b++) begin
            same = 1'b1;
            for (int k = 1; k <= dbc(i) + 1; k++) if (h[k][b] != s[b]) same = 1'b0;
            if (same && s[b] != m_filt[i][b]) fn[b] = s[b];
          end
        end
        case (etype(i))
          0:       ed = m_filt[i] & ~m_fdly[i];
          1:       ed = ~m_filt[i] & m_fdly[i];
          default: ed = m_filt[i] ^ m_fdly[i];
        endcase
        if (ecnt < settle(i)) ed = 8'h00;
        m_filt[i] <= fn;
        m_fdly[i] <= m_filt[i];
        m_ec[i]   <= (m_ec[i] & ~clr) | ed;
        if (cs && !wn && addr == 2'd2) m_mask[i] <= wd[7:0];
        m_irq[i]  <= (itype(i) == 1) ? |(m_ec[i] & m_mask[i]) : |(m_filt[i] & m_mask[i]);
        case (addr)
          2'd0:    m_rd[i] <= {24'd0, m_filt[i]};
          2'd2:    m_rd[i] <= {24'd0, m_mask[i]};
          2'd3:    m_rd[i] <= {24'd0, m_ec[i]};
          default: m_rd[i] <= 32'd0;
        endcase
      end
      h[0] <= in_port;
      for (int k = 1; k < 16; k++) h[k] <= h[k-1];
      if (ecnt < 1000) ecnt <= ecnt + 1;
    end
  end

  always @(negedge clk) begin : compare
    n_cmp = n_cmp + 4;
    if (bus0.readdata !== m_rd[0]) begin
      n_bad++; $display("FAIL cyc_rd0 t=%0t got %h want %h", $time, bus0.readdata, m_rd[0]);
    end
    if (bus1.readdata !== m_rd[1]) begin
      n_bad++; $display("FAIL cyc_rd1 t=%0t got %h want %h", $time, bus1.readdata, m_rd[1]);
    end
    if (irq0 !== m_irq[0]) begin
      n_bad++; $display("FAIL cyc_irq0 t=%0t got %b want %b", $time, irq0, m_irq[0]);
    end
    if (irq1 !== m_irq[1]) begin
      n_bad++; $display("FAIL cyc_irq1 t=%0t got %b want %b", $time, irq1, m_irq[1]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic setin(input logic [7:0] v);
    @(posedge clk); #2 in_port = v;
  endtask

  task automatic rd(input logic [1:0] a);
    @(posedge clk); #2 addr = a;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #2 addr = a; wd = d; cs = 1'b1; wn = 1'b0;
    @(posedge clk); #2 cs = 1'b0; wn = 1'b1;
  endtask

  initial begin
    // Inputs held high through reset must not be captured.
    idle(3);
    #2 reset_n = 1'b1;
    idle(15);
    rd(2'd0); chk("t1_data0", bus0.readdata, 32'h0000_00FF); chk("t1_data1", bus1.readdata, 32'h0000_00FF);
    rd(2'd3); chk("t1_cap0", bus0.readdata, 32'h0); chk("t1_cap1", bus1.readdata, 32'h0);
    chk("t1_irq0", {31'd0, irq0}, 32'h0); chk("t1_irq1", {31'd0, irq1}, 32'h0);

    setin(8'h00); idle(12); wr(2'd3, 32'hFF); idle(2);
    setin(8'h05); idle(12);
    rd(2'd3); chk("t2_cap0", bus0.readdata, 32'h05); chk("t2_cap1", bus1.readdata, 32'h05);
    wr(2'd3, 32'h01);
    rd(2'd3); chk("t2_clr0", bus0.readdata, 32'h04);

    setin(8'h00); idle(12); wr(2'd3, 32'hFF);
    wr(2'd2, 32'h04);
    setin(8'h04); idle(12);
    chk("t3_irq1_set", {31'd0, irq1}, 32'h1); chk("t3_irq0_lvl", {31'd0, irq0}, 32'h1);
    wr(2'd3, 32'h04);
    @(posedge clk); @(negedge clk);
    chk("t3_irq1_clr", {31'd0, irq1}, 32'h0);
    setin(8'h05); idle(12);
    chk("t3_irq1_bit0", {31'd0, irq1}, 32'h0);
    rd(2'd3); chk("t3_cap1", bus1.readdata, 32'h01);

    setin(8'h00); idle(12); wr(2'd3, 32'hFF); idle(2);
    rd(2'd0);
    setin(8'h02); idle(3); #2 in_port = 8'h00;
    idle(12);
    rd(2'd0); chk("t4_glitch_data1", bus1.readdata, 32'h00);
    rd(2'd3); chk("t4_glitch_cap1", bus1.readdata, 32'h00);
    wr(2'd3, 32'hFF); rd(2'd0);
    setin(8'h02); idle(6); #2 in_port = 8'h00;
    @(posedge clk); @(negedge clk); chk("t4_data1_pre", bus1.readdata, 32'h00);
    @(negedge clk); chk("t4_data1_post", bus1.readdata, 32'h02);
    idle(12);
    rd(2'd3); chk("t4_cap1", bus1.readdata, 32'h02);

    wr(2'd3, 32'hFF); idle(12);
    setin(8'h08); idle(3);
    #2 addr = 2'd3; wd = 32'h08; cs = 1'b1; wn = 1'b0;
    @(posedge clk); #2 cs = 1'b0; wn = 1'b1;
    rd(2'd3); chk("t5_setwins0", bus0.readdata, 32'h08);
    idle(12); wr(2'd3, 32'h08);
    rd(2'd3); chk("t5_clr0", bus0.readdata, 32'h00); chk("t5_clr1", bus1.readdata, 32'h00);
    setin(8'h00); idle(12);
    rd(2'd3); chk("t5_fall1", bus1.readdata, 32'h08); chk("t5_nofall0", bus0.readdata, 32'h00);

    wr(2'd2, 32'hFF); wr(2'd3, 32'hFF);
    setin(8'h0F); idle(12);
    rd(2'd3); chk("t6_cap0", bus0.readdata, 32'h0F); chk("t6_cap1", bus1.readdata, 32'h0F);
    chk("t6_irq0", {31'd0, irq0}, 32'h1); chk("t6_irq1", {31'd0, irq1}, 32'h1);
    setin(8'hF0); idle(2);
    @(posedge clk); #3 reset_n = 1'b0; #1;
    chk("t6_rst_rd0", bus0.readdata, 32'h0); chk("t6_rst_rd1", bus1.readdata, 32'h0);
    chk("t6_rst_irq0", {31'd0, irq0}, 32'h0); chk("t6_rst_irq1", {31'd0, irq1}, 32'h0);
    idle(2);
    @(posedge clk); #2 reset_n = 1'b1;
    idle(15);
    rd(2'd3); chk("t6_resettle_cap0", bus0.readdata, 32'h0); chk("t6_resettle_cap1", bus1.readdata, 32'h0);
    rd(2'd0); chk("t6_data0", bus0.readdata, 32'hF0); chk("t6_data1", bus1.readdata, 32'hF0);
    rd(2'd2); chk("t6_mask1", bus1.readdata, 32'h00);
    chk("t6_irq0_end", {31'd0, irq0}, 32'h0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
